// File: rtl/mc_ctrl_pkg.sv
// Shared opcodes, FSM states and datapath select encodings for the multi-cycle controller.
// Optional exception state exists only when MC_CTRL_ILLEGAL_EXC_EN is defined.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [1:0] DEST_RT = 2'd0;
  localparam logic [1:0] DEST_RD = 2'd1;
  localparam logic [1:0] DEST_RA = 2'd2;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_PC     = 2'd2;

  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] EXT_ZERO = 2'd0;
  localparam logic [1:0] EXT_SIGN = 2'd1;
  localparam logic [1:0] EXT_LUI  = 2'd2;

  localparam logic [1:0] ALU_PASSB = 2'd0;
  localparam logic [1:0] ALU_OR    = 2'd1;
  localparam logic [1:0] ALU_SUB   = 2'd2;
  localparam logic [1:0] ALU_ADD   = 2'd3;

  localparam logic [2:0] PC_ALU    = 3'd0;
  localparam logic [2:0] PC_ALUOUT = 3'd1;
  localparam logic [2:0] PC_JUMP   = 3'd2;
  localparam logic [2:0] PC_RS     = 3'd3;
  localparam logic [2:0] PC_EXC    = 3'd4;

  // How the registered pc_we request is qualified at the output.
  localparam logic [1:0] PCWE_NONE   = 2'd0;
  localparam logic [1:0] PCWE_ALWAYS = 2'd1;
  localparam logic [1:0] PCWE_READY  = 2'd2;
  localparam logic [1:0] PCWE_ZERO   = 2'd3;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EX, S_R_WB, S_I_EX, S_I_WB, S_BRANCH, S_JUMP
`ifdef MC_CTRL_ILLEGAL_EXC_EN
    , S_EXC
`endif
  } state_t;

  typedef struct packed {
    logic r_arith;
    logic i_arith;
    logic mem;
    logic branch;
    logic jump;
  } iclass_t;

  typedef struct packed {
    logic [1:0] pc_we_mode;
    logic       ir_on_ready;
    logic       reg_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       iord;
    logic [1:0] dest;
    logic [1:0] wb_sel;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [1:0] ext_mode;
    logic [1:0] aluop;
    logic       set_less;
    logic [2:0] pc_src;
`ifdef MC_CTRL_ILLEGAL_EXC_EN
    logic       illegal;
`endif
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> instruction register / datapath bundle; master drives the selects and strobes.
// The illegal flag is present only when MC_CTRL_ILLEGAL_EXC_EN is defined.
interface mc_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0]       op;
  logic [5:0]       func;
  logic             zero;
  logic             mem_ready;
  logic             pc_we;
  logic             ir_we;
  logic             reg_we;
  logic             mem_rd;
  logic             mem_wr;
  logic             iord;
  logic [1:0]       dest;
  logic [1:0]       wb_sel;
  logic             alu_srca;
  logic [1:0]       alu_srcb;
  logic [1:0]       ext_mode;
  logic [1:0]       aluop;
  logic             set_less;
  logic [2:0]       pc_src;
  logic [CNT_W-1:0] retired;
`ifdef MC_CTRL_ILLEGAL_EXC_EN
  logic             illegal;
`endif

  modport master (
    input  op, func, zero, mem_ready,
    output pc_we, ir_we, reg_we, mem_rd, mem_wr, iord, dest, wb_sel,
           alu_srca, alu_srcb, ext_mode, aluop, set_less, pc_src, retired
`ifdef MC_CTRL_ILLEGAL_EXC_EN
    , output illegal
`endif
  );

  modport slave (
    output op, func, zero, mem_ready,
    input  pc_we, ir_we, reg_we, mem_rd, mem_wr, iord, dest, wb_sel,
           alu_srca, alu_srcb, ext_mode, aluop, set_less, pc_src, retired
`ifdef MC_CTRL_ILLEGAL_EXC_EN
    , input illegal
`endif
  );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational op/func -> one-hot instruction class plus a valid flag.
// Zero latency, no flow control.
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output iclass_t    o_cls,
  output logic       o_valid
);

  always_comb begin
    o_cls = '0;
    case (i_op)
      OP_RTYPE: begin
        case (i_func)
          FN_ADDU, FN_SUBU, FN_SLT: o_cls.r_arith = 1'b1;
          FN_JR:                    o_cls.jump    = 1'b1;
          default: ;
        endcase
      end
      OP_ORI, OP_LUI, OP_ADDI, OP_ADDIU: o_cls.i_arith = 1'b1;
      OP_LW, OP_SW:                      o_cls.mem     = 1'b1;
      OP_BEQ:                            o_cls.branch  = 1'b1;
      OP_J, OP_JAL:                      o_cls.jump    = 1'b1;
      default: ;
    endcase
    o_valid = |o_cls;
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle MIPS control FSM over one shared memory port; 3-5 cycles per instruction, memory states stretch while mem_ready=0.
// MC_CTRL_ILLEGAL_EXC_EN adds an EXC state that vectors undefined instructions to the exception handler.
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
)(
  input  logic       i_clk,
  input  logic       i_reset,
  mc_ctrl_if.master  io_bus
);

  state_t           r_state;
  ctrl_t            r_ctrl;
  logic [CNT_W-1:0] r_retired;
  state_t           w_next;
  iclass_t          w_cls;
  logic             w_valid;
  logic             w_retire;
  logic             w_pc_we;

  mc_ctrl_decode u_decode (
    .i_op    (io_bus.op),
    .i_func  (io_bus.func),
    .o_cls   (w_cls),
    .o_valid (w_valid)
  );

  // Select/strobe pattern for a state; registered so outputs come straight off flops.
  function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] op, input logic [5:0] func);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_rd      = 1'b1;
        c.alu_srcb    = SRCB_FOUR;
        c.aluop       = ALU_ADD;
        c.pc_src      = PC_ALU;
        c.pc_we_mode  = PCWE_READY;
        c.ir_on_ready = 1'b1;
      end
      S_DECODE: begin
        c.alu_srcb = SRCB_IMM_SH2;
        c.ext_mode = EXT_SIGN;
        c.aluop    = ALU_ADD;
      end
      S_MEM_ADDR: begin
        c.alu_srca = 1'b1;
        c.alu_srcb = SRCB_IMM;
        c.ext_mode = EXT_SIGN;
        c.aluop    = ALU_ADD;
      end
      S_MEM_RD: begin
        c.mem_rd = 1'b1;
        c.iord   = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_we = 1'b1;
        c.dest   = DEST_RT;
        c.wb_sel = WB_MDR;
      end
      S_MEM_WR: begin
        c.mem_wr = 1'b1;
        c.iord   = 1'b1;
      end
      S_R_EX: begin
        c.alu_srca = 1'b1;
        c.alu_srcb = SRCB_RT;
        if (func == FN_SUBU) begin
          c.aluop = ALU_SUB;
        end else if (func == FN_SLT) begin
          c.aluop    = ALU_SUB;
          c.set_less = 1'b1;
        end else begin
          c.aluop = ALU_ADD;
        end
      end
      S_R_WB: begin
        c.reg_we = 1'b1;
        c.dest   = DEST_RD;
        c.wb_sel = WB_ALUOUT;
      end
      S_I_EX: begin
        c.alu_srca = 1'b1;
        c.alu_srcb = SRCB_IMM;
        case (op)
          OP_ORI: begin
            c.ext_mode = EXT_ZERO;
            c.aluop    = ALU_OR;
          end
          OP_LUI: begin
            c.ext_mode = EXT_LUI;
            c.aluop    = ALU_PASSB;
          end
          default: begin
            c.ext_mode = EXT_SIGN;
            c.aluop    = ALU_ADD;
          end
        endcase
      end
      S_I_WB: begin
        c.reg_we = 1'b1;
        c.dest   = DEST_RT;
        c.wb_sel = WB_ALUOUT;
      end
      S_BRANCH: begin
        c.alu_srca   = 1'b1;
        c.alu_srcb   = SRCB_RT;
        c.aluop      = ALU_SUB;
        c.pc_src     = PC_ALUOUT;
        c.pc_we_mode = PCWE_ZERO;
      end
      S_JUMP: begin
        c.pc_we_mode = PCWE_ALWAYS;
        if (op == OP_RTYPE) begin
          c.pc_src = PC_RS;
        end else begin
          c.pc_src = PC_JUMP;
          if (op == OP_JAL) begin
            c.reg_we = 1'b1;
            c.dest   = DEST_RA;
            c.wb_sel = WB_PC;
          end
        end
      end
`ifdef MC_CTRL_ILLEGAL_EXC_EN
      S_EXC: begin
        c.illegal    = 1'b1;
        c.pc_we_mode = PCWE_ALWAYS;
        c.pc_src     = PC_EXC;
      end
`endif
      default: ;
    endcase
    return c;
  endfunction

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:  if (io_bus.mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        if (!w_valid) begin
`ifdef MC_CTRL_ILLEGAL_EXC_EN
          w_next = S_EXC;
`else
          w_next = S_FETCH;
`endif
        end else if (w_cls.r_arith) begin
          w_next = S_R_EX;
        end else if (w_cls.i_arith) begin
          w_next = S_I_EX;
        end else if (w_cls.mem) begin
          w_next = S_MEM_ADDR;
        end else if (w_cls.branch) begin
          w_next = S_BRANCH;
        end else begin
          w_next = S_JUMP;
        end
      end
      S_MEM_ADDR: w_next = (io_bus.op == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (io_bus.mem_ready) w_next = S_MEM_WB;
      S_MEM_WR:   if (io_bus.mem_ready) w_next = S_FETCH;
      S_R_EX:     w_next = S_R_WB;
      S_I_EX:     w_next = S_I_WB;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    case (r_state)
      S_R_WB, S_I_WB, S_MEM_WB, S_BRANCH, S_JUMP: w_retire = 1'b1;
      S_MEM_WR:                                   w_retire = io_bus.mem_ready;
      default:                                    w_retire = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= S_FETCH;
      r_ctrl    <= ctrl_for(S_FETCH, io_bus.op, io_bus.func);
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= ctrl_for(w_next, io_bus.op, io_bus.func);
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    case (r_ctrl.pc_we_mode)
      PCWE_ALWAYS: w_pc_we = 1'b1;
      PCWE_READY:  w_pc_we = io_bus.mem_ready;
      PCWE_ZERO:   w_pc_we = io_bus.zero;
      default:     w_pc_we = 1'b0;
    endcase
  end

  // Strobes are held off for as long as reset is high, even mid-access.
  assign io_bus.pc_we    = ~i_reset & w_pc_we;
  assign io_bus.ir_we    = ~i_reset & r_ctrl.ir_on_ready & io_bus.mem_ready;
  assign io_bus.reg_we   = ~i_reset & r_ctrl.reg_we;
  assign io_bus.mem_rd   = ~i_reset & r_ctrl.mem_rd;
  assign io_bus.mem_wr   = ~i_reset & r_ctrl.mem_wr;
  assign io_bus.iord     = r_ctrl.iord;
  assign io_bus.dest     = r_ctrl.dest;
  assign io_bus.wb_sel   = r_ctrl.wb_sel;
  assign io_bus.alu_srca = r_ctrl.alu_srca;
  assign io_bus.alu_srcb = r_ctrl.alu_srcb;
  assign io_bus.ext_mode = r_ctrl.ext_mode;
  assign io_bus.aluop    = r_ctrl.aluop;
  assign io_bus.set_less = r_ctrl.set_less;
  assign io_bus.pc_src   = r_ctrl.pc_src;
  assign io_bus.retired  = r_retired;
`ifdef MC_CTRL_ILLEGAL_EXC_EN
  assign io_bus.illegal  = r_ctrl.illegal;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: instruction table plus hand-written wait/reset/illegal sequences.
// Honours MC_CTRL_ILLEGAL_EXC_EN for the undefined-instruction expectations.
module tb_mc_controller;
  import mc_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mc_ctrl_if #(.CNT_W(32)) bus();

  mc_controller #(.CNT_W(32)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

`ifdef MC_CTRL_ILLEGAL_EXC_EN
  localparam int NOP_CYC   = 3;
  localparam int NOP_PCWE  = 1;
  localparam int NOP_PCSRC = 4;
`else
  localparam int NOP_CYC   = 2;
  localparam int NOP_PCWE  = 0;
  localparam int NOP_PCSRC = -1;
`endif

  typedef struct packed {
    logic       pc_we, ir_we, reg_we, mem_rd, mem_wr, iord;
    logic [1:0] dest, wb_sel;
    logic       alu_srca;
    logic [1:0] alu_srcb, ext_mode, aluop;
    logic       set_less;
    logic [2:0] pc_src;
    logic       illegal;
  } obs_t;

  // -1 in an expected field means "not checked".
  typedef struct {
    string      name;
    logic [5:0] op, func;
    logic       zero;
    int cyc, inc, c2, c2_srca, c2_srcb, c2_aluop, c2_sl, c2_ext;
    int l_reg, l_dest, l_wb, l_pcwe, l_pcsrc, l_memwr;
  } vec_t;

  obs_t tr[32];
  vec_t vt[17];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.pc_we = bus.pc_we;       o.ir_we = bus.ir_we;     o.reg_we = bus.reg_we;
    o.mem_rd = bus.mem_rd;     o.mem_wr = bus.mem_wr;   o.iord = bus.iord;
    o.dest = bus.dest;         o.wb_sel = bus.wb_sel;   o.alu_srca = bus.alu_srca;
    o.alu_srcb = bus.alu_srcb; o.ext_mode = bus.ext_mode;
    o.aluop = bus.aluop;       o.set_less = bus.set_less; o.pc_src = bus.pc_src;
`ifdef MC_CTRL_ILLEGAL_EXC_EN
    o.illegal = bus.illegal;
`else
    o.illegal = 1'b0;
`endif
    return o;
  endfunction

  // Entered during a FETCH cycle; returns during the next FETCH cycle.
  // mem_ready is low for cycles ws..ws+wl-1 of the instruction.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] func, input logic z,
                           input int ws, input int wl, output int ncyc, output int delta);
    logic [31:0] r0;
    bit          prev_f;
    bit          is_f;
    ncyc   = -1;
    delta  = -1;
    prev_f = 1'b0;
    r0     = '0;
    for (int k = 0; k < 32; k++) begin
      if (k > 0) tick();
      bus.op = op; bus.func = func; bus.zero = z;
      bus.mem_ready = !(k >= ws && k < ws + wl);
      #1;
      is_f = bus.mem_rd && !bus.iord;
      if (k == 0) r0 = bus.retired;
      if (k > 0 && is_f && !prev_f) begin
        ncyc  = k;
        delta = int'(bus.retired - r0);
        break;
      end
      tr[k]  = sample();
      prev_f = is_f;
    end
  endtask

  initial begin
    int n, d, cnt;
    total = 0;
    bad   = 0;

    //          name      op     func   z  cyc      inc c2 sa sb al sl ext reg dst wb pcwe      pcsrc      memwr
    vt[0]  = '{"addu",   6'h00, 6'h21, 0, 4,       1,  1, 1, 0, 3, 0, -1, 1,  1,  0, 0,        -1,        0};
    vt[1]  = '{"subu",   6'h00, 6'h23, 0, 4,       1,  1, 1, 0, 2, 0, -1, 1,  1,  0, 0,        -1,        0};
    vt[2]  = '{"slt",    6'h00, 6'h2A, 0, 4,       1,  1, 1, 0, 2, 1, -1, 1,  1,  0, 0,        -1,        0};
    vt[3]  = '{"slt_op", 6'h0A, 6'h2A, 0, NOP_CYC, 0,  0, 0, 0, 0, 0, -1, 0, -1, -1, NOP_PCWE, NOP_PCSRC, 0};
    vt[4]  = '{"add_un", 6'h00, 6'h20, 0, NOP_CYC, 0,  0, 0, 0, 0, 0, -1, 0, -1, -1, NOP_PCWE, NOP_PCSRC, 0};
    vt[5]  = '{"ori",    6'h0D, 6'h00, 0, 4,       1,  1, 1, 2, 1, 0,  0, 1,  0,  0, 0,        -1,        0};
    vt[6]  = '{"lui",    6'h0F, 6'h00, 0, 4,       1,  1, 1, 2, 0, 0,  2, 1,  0,  0, 0,        -1,        0};
    vt[7]  = '{"addi",   6'h08, 6'h3F, 0, 4,       1,  1, 1, 2, 3, 0,  1, 1,  0,  0, 0,        -1,        0};
    vt[8]  = '{"addiu",  6'h09, 6'h2A, 0, 4,       1,  1, 1, 2, 3, 0,  1, 1,  0,  0, 0,        -1,        0};
    vt[9]  = '{"lw",     6'h23, 6'h00, 0, 5,       1,  1, 1, 2, 3, 0,  1, 1,  0,  1, 0,        -1,        0};
    vt[10] = '{"sw",     6'h2B, 6'h00, 0, 4,       1,  1, 1, 2, 3, 0,  1, 0, -1, -1, 0,        -1,        1};
    vt[11] = '{"beq_z0", 6'h04, 6'h00, 0, 3,       1,  1, 1, 0, 2, 0, -1, 0, -1, -1, 0,         1,        0};
    vt[12] = '{"beq_z1", 6'h04, 6'h00, 1, 3,       1,  1, 1, 0, 2, 0, -1, 0, -1, -1, 1,         1,        0};
    vt[13] = '{"j",      6'h02, 6'h00, 0, 3,       1,  0, 0, 0, 0, 0, -1, 0, -1, -1, 1,         2,        0};
    vt[14] = '{"jal",    6'h03, 6'h00, 0, 3,       1,  0, 0, 0, 0, 0, -1, 1,  2,  2, 1,         2,        0};
    vt[15] = '{"jr",     6'h00, 6'h08, 0, 3,       1,  0, 0, 0, 0, 0, -1, 0, -1, -1, 1,         3,        0};
    vt[16] = '{"op3f",   6'h3F, 6'h00, 0, NOP_CYC, 0,  0, 0, 0, 0, 0, -1, 0, -1, -1, NOP_PCWE, NOP_PCSRC, 0};

    // Reset: strobes forced low even with mem_ready high.
    rst = 1'b1; bus.op = '0; bus.func = '0; bus.zero = 1'b0; bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_retired", int'(bus.retired), 0);
    chk("rst_strobes", int'({bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_rd, bus.mem_wr}), 0);
    rst = 1'b0;
    #1;
    chk("rst_first_fetch", int'({bus.mem_rd, bus.iord, bus.ir_we}), 5);

    foreach (vt[i]) begin
      run_instr(vt[i].op, vt[i].func, vt[i].zero, 0, 0, n, d);
      chk({vt[i].name, "_cycles"}, n, vt[i].cyc);
      chk({vt[i].name, "_retired_inc"}, d, vt[i].inc);
      if (n == vt[i].cyc) begin
        // FETCH: {mem_rd,iord,srca,srcb,aluop,pc_src,pc_we,ir_we}
        chk({vt[i].name, "_fetch"}, int'({tr[0].mem_rd, tr[0].iord, tr[0].alu_srca, tr[0].alu_srcb,
            tr[0].aluop, tr[0].pc_src, tr[0].pc_we, tr[0].ir_we}), 12'b1_0_0_01_11_000_1_1);
        // DECODE: {srca,srcb,ext,aluop,pc_we,ir_we,reg_we,mem_rd,mem_wr}
        chk({vt[i].name, "_decode"}, int'({tr[1].alu_srca, tr[1].alu_srcb, tr[1].ext_mode, tr[1].aluop,
            tr[1].pc_we, tr[1].ir_we, tr[1].reg_we, tr[1].mem_rd, tr[1].mem_wr}), 12'b0_11_01_11_00000);
        if (vt[i].c2 != 0) begin
          chk({vt[i].name, "_c2_srca"}, int'(tr[2].alu_srca), vt[i].c2_srca);
          chk({vt[i].name, "_c2_srcb"}, int'(tr[2].alu_srcb), vt[i].c2_srcb);
          chk({vt[i].name, "_c2_aluop"}, int'(tr[2].aluop), vt[i].c2_aluop);
          chk({vt[i].name, "_c2_set_less"}, int'(tr[2].set_less), vt[i].c2_sl);
          if (vt[i].c2_ext >= 0) chk({vt[i].name, "_c2_ext"}, int'(tr[2].ext_mode), vt[i].c2_ext);
        end
        chk({vt[i].name, "_last_reg_we"}, int'(tr[n-1].reg_we), vt[i].l_reg);
        chk({vt[i].name, "_last_pc_we"}, int'(tr[n-1].pc_we), vt[i].l_pcwe);
        chk({vt[i].name, "_last_mem_wr"}, int'(tr[n-1].mem_wr), vt[i].l_memwr);
        if (vt[i].l_dest >= 0)  chk({vt[i].name, "_last_dest"}, int'(tr[n-1].dest), vt[i].l_dest);
        if (vt[i].l_wb >= 0)    chk({vt[i].name, "_last_wb_sel"}, int'(tr[n-1].wb_sel), vt[i].l_wb);
        if (vt[i].l_pcsrc >= 0) chk({vt[i].name, "_last_pc_src"}, int'(tr[n-1].pc_src), vt[i].l_pcsrc);
      end
    end

    // lw with mem_ready low for three MEM_RD cycles.
    run_instr(OP_LW, 6'h00, 1'b0, 3, 3, n, d);
    chk("lw_wait_cycles", n, 8);
    chk("lw_wait_retired_inc", d, 1);
    if (n == 8) begin
      for (int k = 3; k < 7; k++) chk("lw_wait_mem_rd_iord", int'({tr[k].mem_rd, tr[k].iord, tr[k].reg_we}), 6);
      cnt = 0;
      for (int k = 0; k < 8; k++) cnt += int'(tr[k].reg_we);
      chk("lw_wait_reg_we_count", cnt, 1);
      chk("lw_wait_wb_sel", int'({tr[7].reg_we, tr[7].wb_sel}), 3'b1_01);
    end

    // addu with two fetch wait cycles: no IR/PC write until memory is ready.
    run_instr(OP_RTYPE, FN_ADDU, 1'b0, 0, 2, n, d);
    chk("fetch_wait_cycles", n, 6);
    if (n == 6) begin
      chk("fetch_wait_k0", int'({tr[0].mem_rd, tr[0].ir_we, tr[0].pc_we}), 3'b100);
      chk("fetch_wait_k1", int'({tr[1].mem_rd, tr[1].ir_we, tr[1].pc_we}), 3'b100);
      chk("fetch_wait_k2", int'({tr[2].mem_rd, tr[2].ir_we, tr[2].pc_we}), 3'b111);
    end

    // Reset asserted while a store is waiting on memory.
    bus.op = OP_SW; bus.func = 6'h00; bus.mem_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.mem_ready = 1'b0;
    #1;
    chk("sw_wait_mem_wr", int'({bus.mem_wr, bus.iord}), 3);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mid_wait_mem_wr", int'(bus.mem_wr), 0);
    tick();
    bus.mem_ready = 1'b1;
    #1;
    chk("rst_mid_wait_retired", int'(bus.retired), 0);
    chk("rst_mid_wait_strobes", int'({bus.pc_we, bus.ir_we, bus.reg_we, bus.mem_rd, bus.mem_wr}), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst_release_fetch", int'({bus.mem_rd, bus.iord, bus.mem_wr}), 3'b100);
`ifdef MC_CTRL_ILLEGAL_EXC_EN
    chk("rst_release_illegal", int'(bus.illegal), 0);
`endif
    run_instr(OP_RTYPE, FN_ADDU, 1'b0, 0, 0, n, d);
    chk("addu_after_rst_retired", int'(bus.retired), 1);

    // Undefined opcode 3Fh.
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0, n, d);
    chk("illegal_retired_inc", d, 0);
`ifdef MC_CTRL_ILLEGAL_EXC_EN
    chk("illegal_cycles", n, 3);
    if (n == 3) begin
      chk("illegal_decode_flag", int'(tr[1].illegal), 0);
      chk("illegal_exc_pulse", int'({tr[2].illegal, tr[2].pc_we, tr[2].pc_src}), 5'b1_1_100);
    end
    chk("illegal_after_exc", int'(bus.illegal), 0);
`else
    chk("illegal_cycles", n, 2);
    if (n == 2) chk("illegal_decode_pc_we", int'(tr[1].pc_we), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle successor to the single-cycle MIPS control unit. It replaces per-instruction combinational decode with a state machine that sequences fetch, decode, execute, memory and write-back across several clocks over one shared memory port. A memory wait handshake stretches any memory cycle, and a retired-instruction counter runs alongside the state machine. It sits between the instruction register (op/func), the ALU zero flag and the memory ready line on one side, and the multi-cycle datapath select and strobe inputs on the other.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- op  in  6  instruction[31:26] from instruction register
- func  in  6  instruction[5:0] from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- pc_we, ir_we, reg_we, mem_rd, mem_wr  out  1  write/read strobes
- iord  out  1  memory address: 0 PC, 1 ALUOut
- dest  out  2  write register: 0 rt, 1 rd, 2 $31
- wb_sel  out  2  write data: 0 ALUOut, 1 MDR, 2 PC (link)
- alu_srca  out  1  0 PC, 1 rs
- alu_srcb  out  2  0 rt, 1 const 4, 2 ext imm, 3 ext imm<<2
- ext_mode  out  2  0 zero-ext, 1 sign-ext, 2 imm<<16
- aluop  out  2  3 add, 2 sub, 1 or, 0 pass B
- set_less  out  1  ALU result replaced by {31'b0, sign}
- pc_src  out  3  0 ALU, 1 ALUOut, 2 jump target, 3 rs, 4 exception vector
- retired  out  CNT_W  instructions completed since reset
- illegal  out  1  exists only under MC_CTRL_ILLEGAL_EXC_EN

## Operation
- Instruction set:
  - addu (op 0, func 21h), subu (op 0, func 23h), slt (op 0, func 2Ah), jr (op 0, func 08h)
  - ori 0Dh, lui 0Fh, addi/addiu 08h/09h, lw 23h, sw 2Bh, beq 04h, j 02h, jal 03h
  - slt requires op==0 AND func==2Ah.
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EX, R_WB, I_EX, I_WB, BRANCH, JUMP, EXC (EXC only with the macro).
- FETCH:
  - mem_rd=1, iord=0, alu_srca=0, alu_srcb=1, aluop=3, pc_src=0.
  - While mem_ready=0: hold FETCH, ir_we=pc_we=0.
  - When mem_ready=1: ir_we=pc_we=1 -> DECODE.
- DECODE: alu_srca=0, alu_srcb=3, ext_mode=1, aluop=3 (branch target into ALUOut).
  - R-type arith -> R_EX.
  - ori/lui/addi -> I_EX.
  - lw/sw -> MEM_ADDR.
  - beq -> BRANCH.
  - j/jal/jr -> JUMP.
  - Undefined -> FETCH (NOP).
- R_EX: srca=1, srcb=0, aluop add/sub/sub+set_less. Then R_WB: reg_we=1, dest=1, wb_sel=0 -> FETCH.
- I_EX: srca=1, srcb=2.
  - ori: ext 0, aluop 1.
  - lui: ext 2, aluop 0.
  - addi: ext 1, aluop 3.
  - Then I_WB: reg_we=1, dest=0, wb_sel=0 -> FETCH.
- MEM_ADDR: srca=1, srcb=2, ext 1, aluop 3 -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_rd=1, iord=1. Hold until mem_ready, then -> MEM_WB.
- MEM_WB: reg_we=1, dest=0, wb_sel=1 -> FETCH.
- MEM_WR: mem_wr=1, iord=1. Hold until mem_ready, then -> FETCH.
- BRANCH: srca=1, srcb=0, aluop 2, pc_src=1, pc_we=zero -> FETCH.
- JUMP: pc_we=1, then -> FETCH.
  - j: pc_src=2.
  - jal: pc_src=2, plus reg_we=1, dest=2, wb_sel=2 (PC already +4).
  - jr: pc_src=3.
- Outputs are decoded from the state register. Only pc_we/ir_we (mem_ready, zero) are combinationally gated.
- retired increments by 1 on the exit edge of R_WB, I_WB, MEM_WB, MEM_WR (with mem_ready), BRANCH, JUMP. It wraps modulo 2^CNT_W; undefined-op NOPs are not counted.

## Timing
- Latency with mem_ready always 1:
  - 4 cycles: R-type, I-type, sw.
  - 5 cycles: lw.
  - 3 cycles: beq, j, jal, jr.
- Each mem_ready=0 cycle adds one cycle in FETCH/MEM_RD/MEM_WR. Strobes stay stable while waiting.
- Reset (any state, including mid-wait):
  - Next state is FETCH, retired=0, illegal=0.
  - While reset is high, pc_we, ir_we, reg_we, mem_rd, mem_wr are forced to 0.
  - The first FETCH access starts the cycle after reset falls.
- zero is sampled only in BRANCH; mem_ready is ignored outside the three memory states.

## Configuration
- MC_CTRL_ILLEGAL_EXC_EN:
  - Defined: an undefined op/func in DECODE -> EXC.
  - EXC: illegal=1 for that single cycle, pc_we=1, pc_src=4 -> FETCH. Not counted as retired.
  - Undefined: no EXC state, no illegal port; undefined instructions are a 2-cycle NOP and pc_src never takes 4.

## Structure
- Package mc_ctrl_pkg:
  - opcode/func localparams
  - state enum
  - encodings for dest, wb_sel, alu_srcb, ext_mode, aluop, pc_src
- Sub-module mc_ctrl_decode: combinational op/func -> one-hot instruction class plus valid flag, used by DECODE and I_EX/R_EX selection.

## Test plan
- addu (op 0, func 21h), mem_ready=1 -> states FETCH,DECODE,R_EX,R_WB; reg_we=1 with dest=1 in cycle 4; retired 0->1.
- lw with mem_ready low 3 cycles in MEM_RD -> 8-cycle instruction, mem_rd/iord=1 held, reg_we with wb_sel=1 once.
- beq with zero=0 then zero=1 -> pc_we 0 then 1 in BRANCH, pc_src=1; retired +1 each.
- jal -> JUMP cycle shows pc_we=1, pc_src=2, reg_we=1, dest=2, wb_sel=2; jr shows pc_src=3.
- Reset asserted during MEM_WR wait -> mem_wr=0 same cycle, retired=0, FETCH with mem_rd=1 cycle after release.
- op 3Fh: with macro, illegal pulses 1 cycle and pc_src=4; without, returns to FETCH after DECODE, retired unchanged.
